// File: rtl/ls_request_queue_pkg.sv
// Shared types for the load/store request queue: the queued entry layout and a word-address compare helper.
package ls_request_queue_pkg;

  localparam int LS_ID_W = 3;

  // Field order is significant: the flattened head entry on out_entry is {addr,data,be,fn3,load,store,id}.
  typedef struct packed {
    logic [31:0]        addr;
    logic [31:0]        data;
    logic [3:0]         be;
    logic [2:0]         fn3;
    logic               load;
    logic               store;
    logic [LS_ID_W-1:0] id;
  } ls_queue_entry_t;

  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/ls_request_queue_store_match.sv
// Word-granular store hazard detector: flags any valid queued store whose address shares cmp_addr's word.
module ls_queue_store_match
  import ls_request_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  ls_queue_entry_t   entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [31:0]       cmp_addr,
  output logic              hit
);

  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] & entries[i].store & word_match(entries[i].addr, cmp_addr);
    end
  end

  assign hit = |match;

endmodule

// File: rtl/ls_request_queue.sv
// In-order load/store request FIFO between issue and the LS sub-units, with store-hazard lookup and
// idle status. All handshake outputs come from registered state only.
module ls_request_queue
  import ls_request_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = LS_ID_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [31:0]                         in_addr,
  input  logic [31:0]                         in_data,
  input  logic [3:0]                          in_be,
  input  logic [2:0]                          in_fn3,
  input  logic                                in_load,
  input  logic                                in_store,
  input  logic [ID_W-1:0]                     in_id,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_accept,
  output logic [$bits(ls_queue_entry_t)-1:0]  out_entry,
  input  logic [31:0]                         cmp_addr,
  output logic                                cmp_store_hit,
  output logic                                empty,
  output logic [$clog2(DEPTH):0]              count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  ls_queue_entry_t  mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;
  logic [PTR_W:0]   count_r;
  logic [PTR_W-1:0] widx;
  logic [PTR_W-1:0] ridx;
  logic             full;
  logic             push;
  logic             pop;
  ls_queue_entry_t  new_entry;

  assign widx = wptr[PTR_W-1:0];
  assign ridx = rptr[PTR_W-1:0];

  // Pointers carry one extra wrap bit so equal indices can be told apart as full vs empty.
  assign full = (wptr[PTR_W] != rptr[PTR_W]) && (widx == ridx);

  assign in_ready  = ~full;
  assign out_valid = valid[ridx];
  assign push      = in_valid & ~full & ~flush;
  assign pop       = out_valid & out_accept & ~flush;

  always_comb begin
    new_entry       = '0;
    new_entry.addr  = in_addr;
    new_entry.data  = in_data;
    new_entry.be    = in_be;
    new_entry.fn3   = in_fn3;
    new_entry.load  = in_load;
    new_entry.store = in_store;
    new_entry.id    = in_id;
  end

  // Flush behaves exactly like reset, so any push or pop in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_r <= '0;
      valid   <= '0;
    end else begin
      if (push) begin
        valid[widx] <= 1'b1;
        wptr        <= wptr + PTR_ONE;
      end
      if (pop) begin
        valid[ridx] <= 1'b0;
        rptr        <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + PTR_ONE;
        2'b01:   count_r <= count_r - PTR_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage needs no reset; the valid vector qualifies every slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[widx] <= new_entry;
    end
  end

  assign out_entry = mem[ridx];
  assign count     = count_r;
  assign empty     = (count_r == '0);

  ls_queue_store_match #(
    .DEPTH (DEPTH)
  ) u_store_match (
    .entries  (mem),
    .valid    (valid),
    .cmp_addr (cmp_addr),
    .hit      (cmp_store_hit)
  );

endmodule

// File: tb/tb_ls_request_queue.sv
// Scoreboard bench for ls_request_queue: directed pushes feed an expected-entry queue that a negedge
// monitor drains on every accepted head; status outputs are checked against hand-computed values.
module tb_ls_request_queue;
  import ls_request_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int ID_W  = LS_ID_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                               clk;
  logic                               rst;
  logic                               in_valid;
  logic                               in_ready;
  logic [31:0]                        in_addr;
  logic [31:0]                        in_data;
  logic [3:0]                         in_be;
  logic [2:0]                         in_fn3;
  logic                               in_load;
  logic                               in_store;
  logic [ID_W-1:0]                    in_id;
  logic                               flush;
  logic                               out_valid;
  logic                               out_accept;
  logic [$bits(ls_queue_entry_t)-1:0] out_entry;
  logic [31:0]                        cmp_addr;
  logic                               cmp_store_hit;
  logic                               empty;
  logic [CW-1:0]                      count;

  int testsRun    = 0;
  int testsFailed = 0;

  ls_queue_entry_t expQ[$];
  ls_queue_entry_t expE;
  ls_queue_entry_t head;
  ls_queue_entry_t e;

  assign head = out_entry;

  ls_request_queue #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .in_be         (in_be),
    .in_fn3        (in_fn3),
    .in_load       (in_load),
    .in_store      (in_store),
    .in_id         (in_id),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_accept    (out_accept),
    .out_entry     (out_entry),
    .cmp_addr      (cmp_addr),
    .cmp_store_hit (cmp_store_hit),
    .empty         (empty),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ls_queue_entry_t makeEntry(input int id, input logic [31:0] addr,
                                                input logic isStore, input logic isLoad);
    ls_queue_entry_t r;
    r.addr  = addr;
    r.data  = 32'hD000_0000 + id;
    r.be    = isStore ? 4'hF : 4'h0;
    r.fn3   = 3'b010;
    r.load  = isLoad;
    r.store = isStore;
    r.id    = id[ID_W-1:0];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic pushEn, input ls_queue_entry_t ent, input logic accept,
                             input logic doFlush);
    in_valid   = pushEn;
    in_addr    = ent.addr;
    in_data    = ent.data;
    in_be      = ent.be;
    in_fn3     = ent.fn3;
    in_load    = ent.load;
    in_store   = ent.store;
    in_id      = ent.id;
    out_accept = accept;
    flush      = doFlush;
  endtask

  // One clock of stimulus; the scoreboard learns of the push or flush before the edge happens.
  task automatic applyStimulus(input logic pushEn, input ls_queue_entry_t ent, input logic accept,
                               input logic doFlush);
    driveInputs(pushEn, ent, accept, doFlush);
    if (doFlush) expQ.delete();
    else if (pushEn) expQ.push_back(ent);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    out_accept = 1'b0;
    flush      = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && out_accept) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_accept: got out_valid=%0b, expected an empty scoreboard to see no accept", out_valid);
      end else begin
        expE = expQ.pop_front();
        checkOutput("out_valid_on_accept", 32'(out_valid), 32'd1);
        testsRun++;
        if (out_entry !== expE) begin
          testsFailed++;
          $display("[TB] FAIL head_entry: got 0x%0h, expected 0x%0h", out_entry, expE);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    e = makeEntry(0, 32'h0, 1'b0, 1'b0);
    driveInputs(1'b0, e, 1'b0, 1'b0);
    cmp_addr = 32'h0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_hit", 32'(cmp_store_hit), 32'd0);

    // Fill to full with no consumer.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, makeEntry(i, 32'h1000 + 4 * i, 1'b0, 1'b1), 1'b0, 1'b0);
      checkOutput("fill_count", 32'(count), 32'(i + 1));
    end
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("full_head_id", 32'(head.id), 32'd0);

    // A pop while full must not raise in_ready in the same cycle.
    out_accept = 1'b1;
    #1;
    checkOutput("ready_during_pop", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, e, 1'b1, 1'b0);
    checkOutput("after_pop_count", 32'(count), 32'd3);
    checkOutput("after_pop_in_ready", 32'(in_ready), 32'd1);
    checkOutput("after_pop_head_id", 32'(head.id), 32'd1);
    applyStimulus(1'b1, makeEntry(4, 32'h1010, 1'b0, 1'b1), 1'b0, 1'b0);
    checkOutput("wrap_count", 32'(count), 32'd4);
    checkOutput("wrap_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, e, 1'b1, 1'b0);
      checkOutput("drain_count", 32'(count), 32'(3 - i));
    end
    checkOutput("drain_empty", 32'(empty), 32'd1);

    // Store hazard lookup.
    cmp_addr = 32'h8000_0106;
    e = makeEntry(1, 32'h8000_0104, 1'b1, 1'b0);
    driveInputs(1'b1, e, 1'b0, 1'b0);
    #1;
    checkOutput("hit_excludes_push", 32'(cmp_store_hit), 32'd0);
    applyStimulus(1'b1, e, 1'b0, 1'b0);
    checkOutput("hit_same_word", 32'(cmp_store_hit), 32'd1);
    cmp_addr = 32'h8000_0108;
    #1;
    checkOutput("hit_next_word", 32'(cmp_store_hit), 32'd0);
    cmp_addr = 32'h8000_0104;
    out_accept = 1'b1;
    #1;
    checkOutput("hit_while_popping", 32'(cmp_store_hit), 32'd1);
    applyStimulus(1'b0, e, 1'b1, 1'b0);
    checkOutput("hit_after_pop", 32'(cmp_store_hit), 32'd0);
    applyStimulus(1'b1, makeEntry(2, 32'h8000_0104, 1'b0, 1'b1), 1'b0, 1'b0);
    checkOutput("hit_load_only", 32'(cmp_store_hit), 32'd0);
    applyStimulus(1'b0, e, 1'b1, 1'b0);
    checkOutput("hazard_empty", 32'(empty), 32'd1);

    // Steady-state streaming with two resident entries.
    applyStimulus(1'b1, makeEntry(0, 32'h2000, 1'b0, 1'b1), 1'b0, 1'b0);
    applyStimulus(1'b1, makeEntry(1, 32'h2004, 1'b1, 1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, makeEntry((i + 2) % 8, 32'h2008 + 4 * i, i[0], ~i[0]), 1'b1, 1'b0);
      checkOutput("stream_count", 32'(count), 32'd2);
    end
    applyStimulus(1'b0, e, 1'b1, 1'b0);
    applyStimulus(1'b0, e, 1'b1, 1'b0);
    checkOutput("stream_empty", 32'(empty), 32'd1);

    // Flush wins over a simultaneous push.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, makeEntry(i, 32'h3000 + 4 * i, 1'b1, 1'b0), 1'b0, 1'b0);
    end
    checkOutput("preflush_count", 32'(count), 32'd3);
    applyStimulus(1'b1, makeEntry(7, 32'h3100, 1'b1, 1'b0), 1'b0, 1'b1);
    checkOutput("flush_empty", 32'(empty), 32'd1);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);

    // Single entry latency through an empty queue.
    e = makeEntry(5, 32'h4000, 1'b0, 1'b1);
    driveInputs(1'b1, e, 1'b0, 1'b0);
    #1;
    checkOutput("no_fallthrough", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, e, 1'b0, 1'b0);
    checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
    checkOutput("latency_head_id", 32'(head.id), 32'd5);
    applyStimulus(1'b0, e, 1'b1, 1'b0);
    checkOutput("final_empty", 32'(empty), 32'd1);
    checkOutput("final_count", 32'(count), 32'd0);

    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
